// File: rtl/hyper_resp_pkg.sv
// Shared types and command/address field positions for the HyperBus memory responder.
package hyper_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_WR,
    ST_RD
  } hyper_resp_state_e;

  localparam int CA_RW     = 47;
  localparam int CA_AS     = 46;
  localparam int CA_BURST  = 45;
  localparam int CA_ROW_HI = 44;
  localparam int CA_ROW_LO = 16;
  localparam int CA_COL_HI = 2;
  localparam int CA_COL_LO = 0;

  localparam logic [15:0] ID0_DEFAULT = 16'h0C81;

endpackage

// File: rtl/hyper_resp_edge_sync.sv
// Synchronizes all HyperBus inputs through one equal-depth chain and flags CK edges.
module hyper_resp_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ck_i,
  input  logic       cs_ni,
  input  logic       reset_ni,
  input  logic       rwds_i,
  input  logic [7:0] dq_i,
  output logic       cs_n,
  output logic       reset_n,
  output logic       rwds,
  output logic [7:0] dq,
  output logic       ck_edge
);

  // Bundle layout: {ck, cs_n, reset_n, rwds, dq}; idle value keeps CS# and RESET# deasserted.
  localparam logic [11:0] RST_VAL = 12'h600;

  logic [SYNC_STAGES-1:0][11:0] chain;
  logic                         ck_hist;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain   <= {SYNC_STAGES{RST_VAL}};
      ck_hist <= 1'b0;
    end else begin
      chain[0] <= {ck_i, cs_ni, reset_ni, rwds_i, dq_i};
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      ck_hist <= chain[SYNC_STAGES-1][11];
    end
  end

  // DQ/RWDS come from the same stage as the newer CK sample so data lines up with its edge.
  assign ck_edge = chain[SYNC_STAGES-1][11] ^ ck_hist;
  assign cs_n    = chain[SYNC_STAGES-1][10];
  assign reset_n = chain[SYNC_STAGES-1][9];
  assign rwds    = chain[SYNC_STAGES-1][8];
  assign dq      = chain[SYNC_STAGES-1][7:0];

endmodule

// File: rtl/hyper_mem_responder.sv
// HyperBus device-side responder: oversampled link decode, linear bursts into a 16-bit word array.
module hyper_mem_responder
  import hyper_resp_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter int          LATENCY     = 6,
  parameter logic [15:0] ID0         = ID0_DEFAULT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hyper_cs_ni,
  input  logic              hyper_ck_i,
  input  logic              hyper_reset_ni,
  input  logic [7:0]        hyper_dq_i,
  output logic [7:0]        hyper_dq_o,
  output logic              hyper_dq_oe_o,
  input  logic              hyper_rwds_i,
  output logic              hyper_rwds_o,
  output logic              hyper_rwds_oe_o,
  output hyper_resp_state_e dbg_state_o
);

  localparam int AW   = $clog2(MEM_WORDS);
  localparam int EMAX = 6 + 4 * LATENCY;
  localparam int EW   = $clog2(EMAX + 1);

  localparam logic [EW-1:0] E_CA_END = EW'(5);
  localparam logic [EW-1:0] E_RD_GO  = EW'(4 + 4 * LATENCY);
  localparam logic [EW-1:0] E_WR_GO  = EW'(5 + 4 * LATENCY);
  localparam logic [EW-1:0] E_SAT    = EW'(EMAX);

  logic       s_cs_n, s_reset_n, s_rwds, ck_edge;
  logic [7:0] s_dq;

  hyper_resp_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ck_i     (hyper_ck_i),
    .cs_ni    (hyper_cs_ni),
    .reset_ni (hyper_reset_ni),
    .rwds_i   (hyper_rwds_i),
    .dq_i     (hyper_dq_i),
    .cs_n     (s_cs_n),
    .reset_n  (s_reset_n),
    .rwds     (s_rwds),
    .dq       (s_dq),
    .ck_edge  (ck_edge)
  );

  hyper_resp_state_e state;
  logic [EW-1:0]     edge_cnt;
  logic [39:0]       ca_q;
  logic              is_read, is_reg, byte_odd;
  logic [AW-1:0]     addr;
  logic [7:0]        wr_hi;
  logic              wr_mask_hi;

  logic [15:0] mem [MEM_WORDS];

  logic        abort;
  logic [47:0] ca_next;
  logic [31:0] ca_addr;
  logic [15:0] rd_word;
  logic        mem_we, we_hi, we_lo;
  logic        unused_ca;

  assign abort     = s_cs_n | ~s_reset_n;
  assign ca_next   = {ca_q, s_dq};
  assign ca_addr   = {ca_next[CA_ROW_HI:CA_ROW_LO], ca_next[CA_COL_HI:CA_COL_LO]};
  assign unused_ca = ^{ca_next[CA_BURST], ca_next[CA_ROW_LO-1:CA_COL_HI+1], ca_addr[31:AW]};
  assign rd_word   = is_reg ? ID0 : mem[addr];

  // A word is committed on its odd byte; the held high byte and its mask go in alongside.
  assign mem_we = (state == ST_WR) && ck_edge && !abort && byte_odd && !is_reg;
  assign we_hi  = mem_we && !wr_mask_hi;
  assign we_lo  = mem_we && !s_rwds;

  always_ff @(posedge clk_i) begin
    if (we_hi) mem[addr][15:8] <= wr_hi;
    if (we_lo) mem[addr][7:0]  <= s_dq;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || abort) begin
      state           <= ST_IDLE;
      edge_cnt        <= '0;
      byte_odd        <= 1'b0;
      hyper_dq_o      <= 8'h00;
      hyper_dq_oe_o   <= 1'b0;
      hyper_rwds_o    <= 1'b0;
      hyper_rwds_oe_o <= 1'b0;
      if (rst_i) begin
        ca_q       <= '0;
        is_read    <= 1'b0;
        is_reg     <= 1'b0;
        addr       <= '0;
        wr_hi      <= 8'h00;
        wr_mask_hi <= 1'b0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          edge_cnt        <= '0;
          byte_odd        <= 1'b0;
          state           <= ST_CA;
          hyper_rwds_oe_o <= 1'b1;
          hyper_rwds_o    <= 1'b1;
        end
        ST_CA: if (ck_edge) begin
          ca_q     <= ca_next[39:0];
          edge_cnt <= edge_cnt + 1'b1;
          if (edge_cnt == E_CA_END) begin
            is_read         <= ca_next[CA_RW];
            is_reg          <= ca_next[CA_AS];
            addr            <= ca_addr[AW-1:0];
            state           <= ST_LAT;
            hyper_rwds_oe_o <= 1'b0;
            hyper_rwds_o    <= 1'b0;
          end
        end
        ST_LAT: if (ck_edge) begin
          edge_cnt <= edge_cnt + 1'b1;
          if (is_read && edge_cnt == E_RD_GO) begin
            hyper_dq_oe_o   <= 1'b1;
            hyper_rwds_oe_o <= 1'b1;
            hyper_dq_o      <= 8'h00;
            hyper_rwds_o    <= 1'b0;
            state           <= ST_RD;
          end else if (!is_read && edge_cnt == E_WR_GO) begin
            state <= ST_WR;
          end
        end
        ST_WR: if (ck_edge) begin
          edge_cnt <= (edge_cnt == E_SAT) ? E_SAT : edge_cnt + 1'b1;
          byte_odd <= ~byte_odd;
          if (!byte_odd) begin
            wr_hi      <= s_dq;
            wr_mask_hi <= s_rwds;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        ST_RD: if (ck_edge) begin
          edge_cnt     <= (edge_cnt == E_SAT) ? E_SAT : edge_cnt + 1'b1;
          byte_odd     <= ~byte_odd;
          hyper_dq_o   <= byte_odd ? rd_word[7:0] : rd_word[15:8];
          hyper_rwds_o <= ~byte_odd;
          if (byte_odd) addr <= addr + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state_o = state;

endmodule

// File: tb/tb_hyper_mem_responder.sv
// Directed bench: table of write/read bursts plus hand sequences for early CS# and mid-read reset.
module tb_hyper_mem_responder;
  import hyper_resp_pkg::*;

  localparam int LAT  = 6;
  localparam int SYNC = 2;

  logic              clk = 1'b0;
  logic              rst, cs_n, ck, reset_n, rwds;
  logic [7:0]        dq;
  logic [7:0]        dq_o;
  logic              dq_oe, rwds_o, rwds_oe;
  hyper_resp_state_e dbg_state;

  int checks   = 0;
  int failures = 0;

  hyper_mem_responder #(
    .MEM_WORDS(1024), .LATENCY(LAT), .ID0(16'h0C81), .SYNC_STAGES(SYNC)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .hyper_cs_ni     (cs_n),
    .hyper_ck_i      (ck),
    .hyper_reset_ni  (reset_n),
    .hyper_dq_i      (dq),
    .hyper_dq_o      (dq_o),
    .hyper_dq_oe_o   (dq_oe),
    .hyper_rwds_i    (rwds),
    .hyper_rwds_o    (rwds_o),
    .hyper_rwds_oe_o (rwds_oe),
    .dbg_state_o     (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd;
    logic        as_;
    logic [9:0]  addr;
    int          nb;
    logic [31:0] data;
    logic [3:0]  mask;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_edge(input logic [7:0] d, input logic r);
    @(negedge clk);
    dq   = d;
    rwds = r;
    @(negedge clk);
    ck = ~ck;
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [47:0] make_ca(input logic rd, input logic as_, input logic [9:0] a);
    logic [28:0] row;
    row = 29'(a >> 3);
    return {rd, as_, 1'b1, row, 13'd0, a[2:0]};
  endfunction

  task automatic start_cmd(input logic [47:0] ca, input string tag);
    @(negedge clk);
    cs_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      do_edge(ca[47-8*i -: 8], 1'b0);
      if (i == 0) begin
        check({tag, "_ca_rwds_oe"}, 16'(rwds_oe), 16'd1);
        check({tag, "_ca_rwds"}, 16'(rwds_o), 16'd1);
      end
    end
  endtask

  task automatic end_cmd();
    @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    ck   = 1'b0;
    dq   = 8'h00;
    rwds = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic write_lat(input logic as_, input logic [9:0] a, input string tag);
    start_cmd(make_ca(1'b0, as_, a), tag);
    for (int e = 6; e <= 5 + 4 * LAT; e++) begin
      do_edge(8'h00, 1'b0);
      if (e == 6) check({tag, "_lat_rwds_oe"}, 16'(rwds_oe), 16'd0);
    end
  endtask

  task automatic read_lat(input logic as_, input logic [9:0] a, input string tag);
    start_cmd(make_ca(1'b1, as_, a), tag);
    for (int e = 6; e <= 4 + 4 * LAT; e++) do_edge(8'h00, 1'b0);
    check({tag, "_rd_dq_oe"}, 16'(dq_oe), 16'd1);
    check({tag, "_rd_rwds_oe"}, 16'(rwds_oe), 16'd1);
    check({tag, "_rd_pre_rwds"}, 16'(rwds_o), 16'd0);
  endtask

  task automatic read_bytes(input int nb, input logic [31:0] exp, input string tag);
    for (int n = 0; n < nb; n++) begin
      do_edge(8'h00, 1'b0);
      check($sformatf("%s_byte%0d", tag, n), 16'(dq_o), 16'(exp[31-8*n -: 8]));
      check($sformatf("%s_strobe%0d", tag, n), 16'(rwds_o), 16'((n % 2) == 0));
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    if (v.rd) begin
      read_lat(v.as_, v.addr, tag);
      read_bytes(v.nb, v.data, tag);
    end else begin
      write_lat(v.as_, v.addr, tag);
      for (int n = 0; n < v.nb; n++) do_edge(v.data[31-8*n -: 8], v.mask[3-n]);
    end
    end_cmd();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 10'h010, 4, 32'hABCD1234, 4'b0000};
    vecs[1]  = '{1'b1, 1'b0, 10'h010, 4, 32'hABCD1234, 4'b0000};
    vecs[2]  = '{1'b0, 1'b0, 10'h020, 2, 32'hFFFF0000, 4'b0000};
    vecs[3]  = '{1'b0, 1'b0, 10'h020, 2, 32'h00000000, 4'b1000};
    vecs[4]  = '{1'b1, 1'b0, 10'h020, 2, 32'hFF000000, 4'b0000};
    vecs[5]  = '{1'b1, 1'b1, 10'h000, 4, 32'h0C810C81, 4'b0000};
    vecs[6]  = '{1'b0, 1'b1, 10'h010, 2, 32'h55550000, 4'b0000};
    vecs[7]  = '{1'b1, 1'b0, 10'h010, 2, 32'hABCD0000, 4'b0000};
    vecs[8]  = '{1'b0, 1'b0, 10'h3FF, 4, 32'h11112222, 4'b0000};
    vecs[9]  = '{1'b1, 1'b0, 10'h3FF, 2, 32'h11110000, 4'b0000};
    vecs[10] = '{1'b1, 1'b0, 10'h000, 2, 32'h22220000, 4'b0000};
    vecs[11] = '{1'b1, 1'b0, 10'h3FF, 4, 32'h11112222, 4'b0000};
    vecs[12] = '{1'b0, 1'b0, 10'h040, 4, 32'hAAAABBBB, 4'b0000};

    rst     = 1'b1;
    cs_n    = 1'b1;
    ck      = 1'b0;
    reset_n = 1'b1;
    dq      = 8'h00;
    rwds    = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_dq", 16'(dq_o), 16'h0);
    check("reset_dq_oe", 16'(dq_oe), 16'h0);
    check("reset_rwds", 16'(rwds_o), 16'h0);
    check("reset_rwds_oe", 16'(rwds_oe), 16'h0);
    check("reset_state", 16'(dbg_state), 16'(ST_IDLE));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Write to 0x040 cut short after three bytes: only the completed word lands.
    write_lat(1'b0, 10'h040, "early_wr");
    do_edge(8'h12, 1'b0);
    do_edge(8'h34, 1'b0);
    do_edge(8'h56, 1'b0);
    end_cmd();
    read_lat(1'b0, 10'h040, "early_chk");
    read_bytes(4, 32'h1234BBBB, "early_chk");
    end_cmd();

    // CS# raised during a read: both enables must drop within SYNC+2 cycles.
    read_lat(1'b0, 10'h010, "early_rd");
    read_bytes(1, 32'hAB000000, "early_rd");
    @(negedge clk);
    cs_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    check("early_rd_dq_oe_off", 16'(dq_oe), 16'd0);
    check("early_rd_rwds_oe_off", 16'(rwds_oe), 16'd0);
    check("early_rd_state", 16'(dbg_state), 16'(ST_IDLE));
    end_cmd();

    // rst_i in the middle of a read, then a fresh read decodes from edge 0.
    read_lat(1'b0, 10'h010, "rst_rd");
    read_bytes(2, 32'hABCD0000, "rst_rd");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rd_dq", 16'(dq_o), 16'h0);
    check("rst_rd_dq_oe", 16'(dq_oe), 16'h0);
    check("rst_rd_rwds", 16'(rwds_o), 16'h0);
    check("rst_rd_rwds_oe", 16'(rwds_oe), 16'h0);
    check("rst_rd_state", 16'(dbg_state), 16'(ST_IDLE));
    rst = 1'b0;
    end_cmd();
    read_lat(1'b0, 10'h010, "post_rst");
    read_bytes(4, 32'hABCD1234, "post_rst");
    end_cmd();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hyper_mem_responder.md
# hyper_mem_responder

Synthesizable HyperBus memory responder: the device end of the 8-bit HyperBus link driven by our HyperBus controller through the pad frame. It oversamples CK, CS#, DQ and RWDS on the system clock, decodes the 48-bit command/address, and serves linear read/write bursts from an internal word array. It is the HyperRAM stand-in for FPGA emulation and for loop-back simulation of the controller and pad frame.

## Interface
Parameters:
- MEM_WORDS, 1024: 16-bit words in the array (power of two); AW = $clog2(MEM_WORDS).
- LATENCY, 6: initial latency in CK cycles; always applied doubled (2×LATENCY).
- ID0, 16'h0C81: value returned for every register-space read.
- SYNC_STAGES, 2: synchronizer depth applied to all link inputs.

Ports:
- clk_i  in  1  system clock; must be ≥ 4× CK frequency.
- rst_i  in  1  synchronous reset, active-high.
- hyper_cs_ni  in  1  chip select, active-low.
- hyper_ck_i  in  1  HyperBus CK (CK# not used).
- hyper_reset_ni  in  1  device reset from controller, active-low.
- hyper_dq_i  in  8  DQ from controller.
- hyper_dq_o  out  8  DQ to controller.
- hyper_dq_oe_o  out  1  DQ output enable.
- hyper_rwds_i  in  1  RWDS from controller (write mask).
- hyper_rwds_o  out  1  RWDS to controller (latency flag / read strobe).
- hyper_rwds_oe_o  out  1  RWDS output enable.

## Operation
- Inputs pass through SYNC_STAGES flops plus one history flop, all with equal depth so DQ/RWDS stay aligned to CK. A CK edge (either polarity) is detected when the last two CK flops differ; DQ/RWDS are sampled from the same stage. Edges are counted e = 0,1,2… from CS# low.
- States: IDLE, CA, LAT, WR, RD.
- IDLE → CA when synced CS# is low.
- CA: edges 0..5 capture CA[47:40]..CA[7:0]. rwds_oe_o=1, rwds_o=1 (2× latency). After edge 5: CA[47]=1 read, 0 write; CA[46]=1 register space; CA[45] ignored (every burst linear). Word address = {CA[44:16], CA[2:0]} modulo MEM_WORDS. → LAT.
- LAT: rwds_oe_o=0. Write: → WR after edge 5+4·LATENCY. Read: at edge 4+4·LATENCY assert dq_oe_o and rwds_oe_o with dq_o=0, rwds_o=0, → RD.
- WR: byte at edge 6+4·LATENCY+n; even n = word[15:8], odd n = word[7:0]; RWDS=1 masks that byte. Word committed at each odd n; address increments modulo MEM_WORDS (wrap 0x3FF→0x000 at default). Register space: bytes accepted, discarded.
- RD: on edge 5+4·LATENCY+n, drive byte n (even = [15:8], odd = [7:0] of the current word, or of ID0 in register space) and set rwds_o = ~n[0] (rising for even bytes). Address increments after each odd byte, modulo MEM_WORDS.
- Synced CS# high in any state → IDLE next cycle: both OEs low; an uncommitted half-word is dropped.
- Synced hyper_reset_ni low: same as CS# high, held in IDLE while low; array preserved.
- Array contents unaffected by rst_i (undefined after power-up).

## Timing
- Reset values: hyper_dq_o=0, hyper_dq_oe_o=0, hyper_rwds_o=0, hyper_rwds_oe_o=0, state IDLE, counters 0.
- Input-to-detect latency: SYNC_STAGES+1 clk_i cycles; outputs registered, change exactly one clk_i cycle after the detecting cycle.
- Write commit: array updated on the clk_i edge following detection of the odd byte; a read of that address in a later burst returns it.
- CS# high and CK edge detected in the same cycle: CS# wins, edge ignored.
- Edge counter saturates at 6+4·LATENCY; byte index n counts freely (LSB only used).

## Structure
- Package hyper_resp_pkg: state enum, CA bit positions (RW=47, AS=46, BURST=45, row 44:16, column 2:0), ID0 default.
- Sub-module hyper_resp_edge_sync: synchronizer chain for CK/CS#/RESET#/DQ/RWDS, outputs aligned samples plus ck_edge pulse. FSM, counters, and array stay in the top.

## Test plan
- Write 4 bytes AB CD 12 34 to word 0x010, RWDS=0, then read 2 words at 0x010 → bytes AB CD 12 34 returned, rwds_o toggles 1,0,1,0.
- Write 0xFFFF to 0x020, then write 00 00 with RWDS=1 on byte 0 → read returns FF 00.
- Register-space read of 4 bytes → 0C 81 0C 81; a register write leaves the array unchanged.
- Burst write starting at 0x3FF, 2 words 1111/2222 → 0x3FF=1111, 0x000=2222.
- CS# high after 3 data bytes of write to 0x040 → word 0x040 updated, 0x041 unchanged; OEs low within SYNC_STAGES+2 clk_i cycles.
- rst_i asserted mid-read → all outputs 0 next cycle, IDLE; next read command is decoded from edge 0.
